awe_dsp_input_seq_mux: RTL and testbench
========================================

# awe_dsp_input_seq_mux

Parametrised, registered N:1 operand selector in front of each AWE DSP slice. It replaces the fixed 4:1 combinational selector. It adds a synchronous config port, a round-robin sweep mode, and a serialising burst mode. In burst mode one captured N-wide input vector feeds the DSP over N consecutive cycles. All outputs are registered with a valid/ready handshake, so the block sits directly between the operand fabric and the DSP input register.

## Interface
- C_DATA_WIDTH, 18, width of each input channel and of dataout
- C_NUM_INPUTS, 4, number of input channels; legal range 2..16, power of two not required
- Derived localparam C_SEL_WIDTH = max(1, clog2(C_NUM_INPUTS))

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  config write strobe
- cfg_mode  in  2  00 STATIC, 01 SWEEP, 10 BURST, 11 ZERO
- cfg_sel  in  C_SEL_WIDTH  STATIC channel, or SWEEP start channel
- cfg_ready  out  1  config accepted when cfg_valid && cfg_ready
- cfg_err  out  1  one-cycle pulse when a config write is rejected (cfg_sel >= C_NUM_INPUTS)
- datain  in  C_NUM_INPUTS*C_DATA_WIDTH  channel k at bits [k*C_DATA_WIDTH +: C_DATA_WIDTH]
- datain_valid  in  1  input beat valid
- datain_ready  out  1  input beat accepted when datain_valid && datain_ready
- dataout  out  C_DATA_WIDTH  selected operand, registered
- dataout_valid  out  1  dataout qualifier
- dataout_sel  out  C_SEL_WIDTH  channel index that produced dataout

## Operation
- Config registers: mode_r and sel_r. Reset values are 00 and 0.
- A config write with a legal sel updates both registers, effective from the next cycle.
- A config write with an illegal sel changes neither register and raises cfg_err for 1 cycle.
- cfg_ready = (state == IDLE). A write while cfg_ready = 0 is ignored, with no cfg_err.
- If a config write and a data beat are accepted in the same cycle, the beat uses the old config.
- STATIC: each accepted beat outputs channel sel_r. datain_ready = 1.
- SWEEP:
  - Pointer ptr is loaded with cfg_sel on every config write.
  - Each accepted beat outputs channel ptr, then ptr advances by 1.
  - Wrap is C_NUM_INPUTS-1 -> 0, including non-power-of-two N. datain_ready = 1.
- ZERO: each accepted beat outputs dataout = 0, dataout_valid = 1, dataout_sel = 0. datain_ready = 1.
- BURST state machine, states IDLE and EMIT, counter cnt:
  - IDLE: datain_ready = 1. An accepted beat loads the full datain vector into a holding register, sets cnt = 0, and goes to EMIT.
  - EMIT: each cycle outputs holding[cnt] with dataout_sel = cnt and increments cnt. The burst has no output stall.
  - When cnt == C_NUM_INPUTS-1: datain_ready = 1.
    - If a beat is accepted that cycle, the holding register reloads, cnt = 0, and the state stays EMIT (back-to-back bursts with no bubble).
    - Otherwise the state returns to IDLE.
  - datain_ready = 0 in EMIT while cnt < C_NUM_INPUTS-1. Beats offered then are not accepted.
- Reset values: dataout = 0, dataout_valid = 0, dataout_sel = 0, cfg_err = 0, ptr = 0, cnt = 0, state = IDLE.
  - cfg_ready and datain_ready read 1 during and after reset.
- Reset mid-burst aborts the burst. The cycle after rst, dataout_valid = 0, and no remaining elements are emitted.

## Timing
- STATIC, SWEEP and ZERO: latency 1. A beat accepted at edge T appears on dataout/dataout_valid after edge T and holds for exactly one cycle.
  - With no beat accepted, dataout_valid = 0 and dataout holds its last value.
- BURST: a beat accepted at edge T produces elements 0..N-1 on the N cycles after T. dataout_valid is continuously 1.
- Sustained throughput is 1 operand/cycle in all modes.
- cfg_err is asserted the cycle after the rejected write.

## Test plan
- Reset, then STATIC: N=4, W=18. Write mode=00, sel=2. Drive datain = {4:0x3, 3:0x..., chans 0..3 = 0x11,0x22,0x33,0x44} valid for 3 cycles -> dataout 0x33 three times, dataout_sel=2, latency 1.
- SWEEP wrap, N=5: write mode=01, sel=3. Send 7 valid beats -> dataout_sel sequence 3,4,0,1,2,3,4.
- BURST back-to-back, N=4: hold datain_valid high with vectors A then B -> 8 contiguous valid outputs A0..A3,B0..B3. datain_ready is low for 3 of every 4 cycles; cfg_ready is low during EMIT.
- Illegal config, N=5: write sel=6 -> cfg_err pulses 1 cycle and the prior mode/sel persists. Same-cycle config write plus beat -> the beat uses the old selection.
- ZERO mode: write mode=11 with datain all-ones -> dataout = 0 with dataout_valid = 1 per beat.
- Reset mid-burst: assert rst at cnt=1 -> the cycle after reset dataout_valid = 0, state is IDLE, and the next beat starts a new burst at element 0.

Source files
------------

// File: rtl/awe_dsp_input_seq_mux_if.sv
// Operand-selector bus: config port, N-wide input beat port and registered operand output.
// The master side drives config and input beats; the slave side is the selector itself.
interface awe_dsp_input_seq_mux_if #(
    parameter int C_DATA_WIDTH = 18,
    parameter int C_NUM_INPUTS = 4
);
    localparam int C_SEL_WIDTH = (C_NUM_INPUTS > 2) ? $clog2(C_NUM_INPUTS) : 1;

    logic                                   cfg_valid;
    logic [1:0]                             cfg_mode;
    logic [C_SEL_WIDTH-1:0]                 cfg_sel;
    logic                                   cfg_ready;
    logic                                   cfg_err;
    logic [C_NUM_INPUTS*C_DATA_WIDTH-1:0]   datain;
    logic                                   datain_valid;
    logic                                   datain_ready;
    logic [C_DATA_WIDTH-1:0]                dataout;
    logic                                   dataout_valid;
    logic [C_SEL_WIDTH-1:0]                 dataout_sel;

    modport master (
        output cfg_valid, cfg_mode, cfg_sel, datain, datain_valid,
        input  cfg_ready, cfg_err, datain_ready, dataout, dataout_valid, dataout_sel
    );

    modport slave (
        input  cfg_valid, cfg_mode, cfg_sel, datain, datain_valid,
        output cfg_ready, cfg_err, datain_ready, dataout, dataout_valid, dataout_sel
    );
endinterface

// File: rtl/awe_dsp_input_seq_mux.sv
// Registered N:1 operand selector feeding an AWE DSP slice, with static, sweep,
// zero and burst (one captured vector serialised over N cycles) modes.
module awe_dsp_input_seq_mux #(
    parameter int C_DATA_WIDTH = 18,
    parameter int C_NUM_INPUTS = 4
) (
    input logic                    clk,
    input logic                    rst,
    awe_dsp_input_seq_mux_if.slave bus
);
    localparam int C_SEL_WIDTH = (C_NUM_INPUTS > 2) ? $clog2(C_NUM_INPUTS) : 1;
    localparam logic [C_SEL_WIDTH-1:0] LAST_SEL = C_SEL_WIDTH'(C_NUM_INPUTS - 1);

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_SWEEP  = 2'b01,
        MODE_BURST  = 2'b10,
        MODE_ZERO   = 2'b11
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    mode_e                   mode_r;
    logic [C_SEL_WIDTH-1:0]  sel_r;
    logic [C_SEL_WIDTH-1:0]  ptr;
    logic [C_SEL_WIDTH-1:0]  cnt;
    logic [C_SEL_WIDTH-1:0]  cnt_next;
    state_e                  state;
    state_e                  state_next;
    logic                    hold_load;

    logic [C_DATA_WIDTH-1:0] chan    [C_NUM_INPUTS];
    logic [C_DATA_WIDTH-1:0] holding [C_NUM_INPUTS];

    logic [C_DATA_WIDTH-1:0] dout_r;
    logic [C_DATA_WIDTH-1:0] dout_next;
    logic [C_SEL_WIDTH-1:0]  dsel_r;
    logic [C_SEL_WIDTH-1:0]  dsel_next;
    logic                    dvalid_r;
    logic                    dvalid_next;
    logic                    cfg_err_r;

    logic cfg_ready_w;
    logic din_ready_w;
    logic cfg_accept;
    logic cfg_legal;
    logic beat_accept;

    // Readies are forced high while reset is asserted so upstream never sees a stall glitch.
    assign cfg_ready_w = rst || (state == IDLE);
    assign din_ready_w = rst || (state == IDLE) || (cnt == LAST_SEL);
    assign cfg_accept  = bus.cfg_valid && cfg_ready_w;
    assign cfg_legal   = int'(bus.cfg_sel) < C_NUM_INPUTS;
    assign beat_accept = bus.datain_valid && din_ready_w;

    always_comb begin
        for (int k = 0; k < C_NUM_INPUTS; k++) begin
            chan[k] = bus.datain[k*C_DATA_WIDTH +: C_DATA_WIDTH];
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        hold_load  = 1'b0;
        case (state)
            IDLE: begin
                if (beat_accept && (mode_r == MODE_BURST)) begin
                    hold_load  = 1'b1;
                    cnt_next   = '0;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                // cnt tracks the element currently on dataout; the last one reopens the input.
                if (cnt != LAST_SEL) begin
                    cnt_next = cnt + 1'b1;
                end else begin
                    cnt_next = '0;
                    if (beat_accept) begin
                        hold_load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        dout_next   = dout_r;
        dsel_next   = dsel_r;
        dvalid_next = 1'b0;
        if ((state == EMIT) && (cnt != LAST_SEL)) begin
            dvalid_next = 1'b1;
            dout_next   = holding[cnt_next];
            dsel_next   = cnt_next;
        end else if (beat_accept) begin
            dvalid_next = 1'b1;
            case (mode_r)
                MODE_STATIC: begin
                    dout_next = chan[sel_r];
                    dsel_next = sel_r;
                end
                MODE_SWEEP: begin
                    dout_next = chan[ptr];
                    dsel_next = ptr;
                end
                MODE_BURST: begin
                    // Element 0 goes straight out so the burst starts the cycle after capture.
                    dout_next = chan[0];
                    dsel_next = '0;
                end
                default: begin
                    dout_next = '0;
                    dsel_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mode_r    <= MODE_STATIC;
            sel_r     <= '0;
            ptr       <= '0;
            dout_r    <= '0;
            dsel_r    <= '0;
            dvalid_r  <= 1'b0;
            cfg_err_r <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            dout_r    <= dout_next;
            dsel_r    <= dsel_next;
            dvalid_r  <= dvalid_next;
            cfg_err_r <= cfg_accept && !cfg_legal;
            // A same-cycle legal config write wins over the sweep advance.
            if (cfg_accept && cfg_legal) begin
                mode_r <= mode_e'(bus.cfg_mode);
                sel_r  <= bus.cfg_sel;
                ptr    <= bus.cfg_sel;
            end else if (beat_accept && (mode_r == MODE_SWEEP)) begin
                ptr <= (ptr == LAST_SEL) ? '0 : ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (hold_load) begin
            holding <= chan;
        end
    end

    assign bus.cfg_ready     = cfg_ready_w;
    assign bus.cfg_err       = cfg_err_r;
    assign bus.datain_ready  = din_ready_w;
    assign bus.dataout       = dout_r;
    assign bus.dataout_valid = dvalid_r;
    assign bus.dataout_sel   = dsel_r;
endmodule

// File: tb/tb_awe_dsp_input_seq_mux.sv
// Directed bench: a vector table drives an N=4 instance; hand-written sequences drive N=5.
module tb_awe_dsp_input_seq_mux;
    localparam int W = 18;

    logic clk = 1'b0;
    logic rst4;
    logic rst5;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    awe_dsp_input_seq_mux_if #(.C_DATA_WIDTH(W), .C_NUM_INPUTS(4)) bus4 ();
    awe_dsp_input_seq_mux_if #(.C_DATA_WIDTH(W), .C_NUM_INPUTS(5)) bus5 ();

    awe_dsp_input_seq_mux #(.C_DATA_WIDTH(W), .C_NUM_INPUTS(4)) dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (bus4)
    );

    awe_dsp_input_seq_mux #(.C_DATA_WIDTH(W), .C_NUM_INPUTS(5)) dut5 (
        .clk (clk),
        .rst (rst5),
        .bus (bus5)
    );

    typedef struct {
        logic        rst;
        logic        cv;
        logic [1:0]  mode;
        logic [1:0]  sel;
        logic [71:0] din;
        logic        dv;
        logic        exp_cr;
        logic        exp_dr;
        logic [17:0] exp_dout;
        logic        exp_dval;
        logic [1:0]  exp_dsel;
        logic        exp_err;
    } vec_t;

    localparam logic [71:0] VA   = {18'h44, 18'h33, 18'h22, 18'h11};
    localparam logic [71:0] VB   = {18'h88, 18'h77, 18'h66, 18'h55};
    localparam logic [71:0] ONES = '1;
    localparam logic [89:0] D5   = {18'h104, 18'h103, 18'h102, 18'h101, 18'h100};

    vec_t tv[$];

    function automatic vec_t mk(logic r, logic cv, logic [1:0] mode, logic [1:0] sel,
                                logic [71:0] din, logic dv, logic cr, logic dr,
                                logic [17:0] dout, logic dval, logic [1:0] dsel, logic err);
        vec_t v;
        v.rst = r;       v.cv = cv;         v.mode = mode;     v.sel = sel;
        v.din = din;     v.dv = dv;         v.exp_cr = cr;     v.exp_dr = dr;
        v.exp_dout = dout; v.exp_dval = dval; v.exp_dsel = dsel; v.exp_err = err;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(vec_t v);
        rst4              = v.rst;
        bus4.cfg_valid    = v.cv;
        bus4.cfg_mode     = v.mode;
        bus4.cfg_sel      = v.sel;
        bus4.datain       = v.din;
        bus4.datain_valid = v.dv;
    endtask

    task automatic check_output(int i, vec_t v);
        check($sformatf("v%0d dataout", i),       32'(bus4.dataout),       32'(v.exp_dout));
        check($sformatf("v%0d dataout_valid", i), 32'(bus4.dataout_valid), 32'(v.exp_dval));
        check($sformatf("v%0d dataout_sel", i),   32'(bus4.dataout_sel),   32'(v.exp_dsel));
        check($sformatf("v%0d cfg_err", i),       32'(bus4.cfg_err),       32'(v.exp_err));
    endtask

    task automatic drive5(logic cv, logic [1:0] mode, logic [2:0] sel, logic dv);
        bus5.cfg_valid    = cv;
        bus5.cfg_mode     = mode;
        bus5.cfg_sel      = sel;
        bus5.datain       = D5;
        bus5.datain_valid = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic check5(string name, logic dval, logic [2:0] dsel, logic [17:0] dout, logic err);
        check({name, " dataout_valid"}, 32'(bus5.dataout_valid), 32'(dval));
        if (dval) begin
            check({name, " dataout_sel"}, 32'(bus5.dataout_sel), 32'(dsel));
            check({name, " dataout"},     32'(bus5.dataout),     32'(dout));
        end
        check({name, " cfg_err"}, 32'(bus5.cfg_err), 32'(err));
    endtask

    initial begin
        //                rst cv mode   sel   din   dv cr dr dout    dval dsel  err
        tv.push_back(mk(1, 0, 2'b00, 2'd0, VA,   0, 1, 1, 18'h00, 0, 2'd0, 0)); // 0 reset
        tv.push_back(mk(0, 1, 2'b00, 2'd2, VA,   0, 1, 1, 18'h00, 0, 2'd0, 0)); // 1 STATIC sel 2
        tv.push_back(mk(0, 0, 2'b00, 2'd0, VA,   1, 1, 1, 18'h33, 1, 2'd2, 0));
        tv.push_back(mk(0, 0, 2'b00, 2'd0, VA,   1, 1, 1, 18'h33, 1, 2'd2, 0));
        tv.push_back(mk(0, 0, 2'b00, 2'd0, VA,   1, 1, 1, 18'h33, 1, 2'd2, 0));
        tv.push_back(mk(0, 0, 2'b00, 2'd0, VA,   0, 1, 1, 18'h33, 0, 2'd2, 0)); // 5 hold, valid low
        tv.push_back(mk(0, 1, 2'b01, 2'd3, VA,   1, 1, 1, 18'h33, 1, 2'd2, 0)); // 6 SWEEP write + beat: old cfg
        tv.push_back(mk(0, 0, 2'b00, 2'd0, VA,   1, 1, 1, 18'h44, 1, 2'd3, 0));
        tv.push_back(mk(0, 0, 2'b00, 2'd0, VA,   1, 1, 1, 18'h11, 1, 2'd0, 0)); // 8 wrap 3 -> 0
        tv.push_back(mk(0, 1, 2'b11, 2'd0, VA,   1, 1, 1, 18'h22, 1, 2'd1, 0)); // 9 ZERO write + beat: old ptr
        tv.push_back(mk(0, 0, 2'b00, 2'd0, ONES, 1, 1, 1, 18'h00, 1, 2'd0, 0)); // 10 ZERO with all-ones
        tv.push_back(mk(0, 0, 2'b00, 2'd0, ONES, 0, 1, 1, 18'h00, 0, 2'd0, 0));
        tv.push_back(mk(0, 1, 2'b10, 2'd0, VA,   0, 1, 1, 18'h00, 0, 2'd0, 0)); // 12 BURST
        tv.push_back(mk(0, 0, 2'b00, 2'd0, VA,   1, 1, 1, 18'h11, 1, 2'd0, 0)); // 13 capture A
        tv.push_back(mk(0, 0, 2'b00, 2'd0, VB,   1, 0, 0, 18'h22, 1, 2'd1, 0));
        tv.push_back(mk(0, 0, 2'b00, 2'd0, VB,   1, 0, 0, 18'h33, 1, 2'd2, 0));
        tv.push_back(mk(0, 0, 2'b00, 2'd0, VB,   1, 0, 0, 18'h44, 1, 2'd3, 0));
        tv.push_back(mk(0, 0, 2'b00, 2'd0, VB,   1, 0, 1, 18'h55, 1, 2'd0, 0)); // 17 back-to-back B
        tv.push_back(mk(0, 0, 2'b00, 2'd0, VB,   1, 0, 0, 18'h66, 1, 2'd1, 0));
        tv.push_back(mk(0, 0, 2'b00, 2'd0, VB,   0, 0, 0, 18'h77, 1, 2'd2, 0));
        tv.push_back(mk(0, 0, 2'b00, 2'd0, VB,   0, 0, 0, 18'h88, 1, 2'd3, 0));
        tv.push_back(mk(0, 0, 2'b00, 2'd0, VB,   0, 0, 1, 18'h88, 0, 2'd3, 0)); // 21 burst ends
        tv.push_back(mk(0, 0, 2'b00, 2'd0, VB,   0, 1, 1, 18'h88, 0, 2'd3, 0));
        tv.push_back(mk(0, 0, 2'b00, 2'd0, VA,   1, 1, 1, 18'h11, 1, 2'd0, 0)); // 23 new burst
        tv.push_back(mk(0, 0, 2'b00, 2'd0, VA,   0, 0, 0, 18'h22, 1, 2'd1, 0));
        tv.push_back(mk(1, 0, 2'b00, 2'd0, VA,   0, 1, 1, 18'h00, 0, 2'd0, 0)); // 25 reset at cnt 1
        tv.push_back(mk(0, 1, 2'b10, 2'd0, VB,   0, 1, 1, 18'h00, 0, 2'd0, 0));
        tv.push_back(mk(0, 0, 2'b00, 2'd0, VB,   1, 1, 1, 18'h55, 1, 2'd0, 0)); // 27 restart at element 0
        tv.push_back(mk(0, 0, 2'b00, 2'd0, VB,   0, 0, 0, 18'h66, 1, 2'd1, 0));

        rst5 = 1'b1;
        bus5.cfg_valid    = 1'b0;
        bus5.cfg_mode     = 2'b00;
        bus5.cfg_sel      = '0;
        bus5.datain       = '0;
        bus5.datain_valid = 1'b0;

        foreach (tv[i]) begin
            apply_stimulus(tv[i]);
            #1;
            check($sformatf("v%0d cfg_ready", i),    32'(bus4.cfg_ready),    32'(tv[i].exp_cr));
            check($sformatf("v%0d datain_ready", i), 32'(bus4.datain_ready), 32'(tv[i].exp_dr));
            @(posedge clk);
            #1;
            check_output(i, tv[i]);
        end
        bus4.cfg_valid    = 1'b0;
        bus4.datain_valid = 1'b0;

        // N=5: sweep wrap across a non-power-of-two channel count.
        rst5 = 1'b0;
        drive5(1'b1, 2'b01, 3'd3, 1'b0);
        check5("n5 sweep cfg", 1'b0, 3'd0, 18'h0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            logic [2:0] es;
            es = 3'((3 + i) % 5);
            drive5(1'b0, 2'b00, 3'd0, 1'b1);
            check5($sformatf("n5 sweep beat%0d", i), 1'b1, es, 18'h100 + 18'(es), 1'b0);
        end

        // Illegal select: error pulse, configuration untouched.
        check("n5 cfg_ready before bad write", 32'(bus5.cfg_ready), 32'd1);
        drive5(1'b1, 2'b00, 3'd6, 1'b0);
        check5("n5 bad cfg", 1'b0, 3'd0, 18'h0, 1'b1);
        drive5(1'b0, 2'b00, 3'd0, 1'b0);
        check5("n5 err clears", 1'b0, 3'd0, 18'h0, 1'b0);
        drive5(1'b0, 2'b00, 3'd0, 1'b1);
        check5("n5 still sweep", 1'b1, 3'd0, 18'h100, 1'b0);

        // Config write and beat together: beat sees the old sweep pointer.
        drive5(1'b1, 2'b00, 3'd4, 1'b1);
        check5("n5 cfg+beat old", 1'b1, 3'd1, 18'h101, 1'b0);
        drive5(1'b0, 2'b00, 3'd0, 1'b1);
        check5("n5 static sel4 a", 1'b1, 3'd4, 18'h104, 1'b0);
        drive5(1'b0, 2'b00, 3'd0, 1'b1);
        check5("n5 static sel4 b", 1'b1, 3'd4, 18'h104, 1'b0);
        drive5(1'b0, 2'b00, 3'd0, 1'b0);
        check5("n5 idle", 1'b0, 3'd0, 18'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
